string_op_engine: RTL and testbench

//  Byte-serial string processing core behind the String HW Avalon register file.

---
 rtl/string_op_engine.sv | 172 +++++++++++++++++
 tb/tb_string_op_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/string_op_engine.sv
// Byte-serial string engine: STRLEN, STRCMP, TOUPPER, TOLOWER and FIND over
// two packed string buffers, one byte per clock, with a held done/Result pair.
module string_op_engine #(
  parameter int MAX_BLOCKS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go,
  input  logic [3:0]                   index,
  input  logic [7:0]                   length,
  input  logic [0:MAX_BLOCKS-1][31:0]  A,
  input  logic [0:MAX_BLOCKS-1][31:0]  B,
  output logic                         done,
  output logic [0:MAX_BLOCKS-1][31:0]  Result
);

  localparam int NB = 4 * MAX_BLOCKS;
  localparam int PW = $clog2(NB);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state;
  logic           go_q;
  logic           armed;
  logic [3:0]     op;
  logic [LW-1:0]  len_n;
  logic [PW-1:0]  ptr;
  logic [7:0]     a_q   [NB];
  logic [7:0]     b_q   [NB];
  logic [7:0]     res_q [NB];
  logic [7:0]     a_in  [NB];
  logic [7:0]     b_in  [NB];

  for (genvar w = 0; w < MAX_BLOCKS; w++) begin : g_word
    for (genvar j = 0; j < 4; j++) begin : g_byte
      assign a_in[4*w+j]         = A[w][8*j +: 8];
      assign b_in[4*w+j]         = B[w][8*j +: 8];
      assign Result[w][8*j +: 8] = res_q[4*w+j];
    end
  end

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
  endfunction

  logic [LW-1:0]     eff_len;
  logic              start;
  logic              last;
  logic [7:0]        a_cur;
  logic [7:0]        b_cur;
  logic signed [8:0] diff;
  logic              finish;
  logic              w0_we;
  logic [31:0]       w0_val;
  logic              bw_we;
  logic [7:0]        bw_val;

  always_comb begin
    if (length == 8'd0 || length > 8'(NB)) eff_len = LW'(NB);
    else                                   eff_len = LW'(length);
  end

  // A start needs go seen low since reset, so a level held through reset is ignored.
  assign start = (state != RUN) && armed && go && !go_q;
  assign last  = ({1'b0, ptr} == len_n - LW'(1));
  assign a_cur = a_q[ptr];
  assign b_cur = b_q[ptr];
  assign diff  = $signed({1'b0, a_cur}) - $signed({1'b0, b_cur});

  always_comb begin
    finish = 1'b0;
    w0_we  = 1'b0;
    w0_val = '0;
    bw_we  = 1'b0;
    bw_val = a_cur;
    case (op)
      4'd0: begin
        if (a_cur == 8'h00) begin
          finish = 1'b1;
        end else begin
          w0_we  = 1'b1;
          w0_val = 32'(ptr) + 32'd1;
          finish = last;
        end
      end
      4'd1: begin
        if (a_cur != b_cur || a_cur == 8'h00) begin
          finish = 1'b1;
          w0_we  = 1'b1;
          w0_val = {{23{diff[8]}}, diff};
        end else begin
          finish = last;
        end
      end
      4'd2: begin
        bw_we  = 1'b1;
        bw_val = to_upper(a_cur);
        finish = last;
      end
      4'd3: begin
        bw_we  = 1'b1;
        bw_val = to_lower(a_cur);
        finish = last;
      end
      4'd4: begin
        if (a_cur == b_q[0]) begin
          finish = 1'b1;
          w0_we  = 1'b1;
          w0_val = 32'(ptr);
        end else if (a_cur == 8'h00 || last) begin
          finish = 1'b1;
          w0_we  = 1'b1;
          w0_val = 32'hFFFF_FFFF;
        end
      end
      default: finish = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      go_q  <= 1'b0;
      armed <= 1'b0;
      op    <= '0;
      len_n <= '0;
      ptr   <= '0;
      a_q   <= '{default: 8'h00};
      b_q   <= '{default: 8'h00};
      res_q <= '{default: 8'h00};
    end else begin
      go_q <= go;
      if (!go) armed <= 1'b1;
      case (state)
        RUN: begin
          if (bw_we) res_q[ptr] <= bw_val;
          if (w0_we) begin
            res_q[0] <= w0_val[7:0];
            res_q[1] <= w0_val[15:8];
            res_q[2] <= w0_val[23:16];
            res_q[3] <= w0_val[31:24];
          end
          if (finish) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            ptr <= ptr + PW'(1);
          end
        end
        default: begin
          if (start) begin
            op    <= index;
            len_n <= eff_len;
            a_q   <= a_in;
            b_q   <= b_in;
            res_q <= '{default: 8'h00};
            done  <= 1'b0;
            ptr   <= '0;
            state <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_string_op_engine.sv
// Directed bench for string_op_engine: a string-level reference model predicts
// the result and latency of each operation and is checked every cycle.
module tb_string_op_engine;

  logic             clk = 1'b0;
  logic             reset;
  logic             go;
  logic [3:0]       index;
  logic [7:0]       length;
  logic [0:1][31:0] A;
  logic [0:1][31:0] B;
  logic             done;
  logic [0:1][31:0] Result;

  string_op_engine #(.MAX_BLOCKS(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .index  (index),
    .length (length),
    .A      (A),
    .B      (B),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bytes_t [8];

  int          checks   = 0;
  int          failures = 0;
  bit          tracking = 1'b0;
  int          cyc      = 0;
  int          exp_lat  = 0;
  logic [63:0] exp_res  = '0;

  function automatic bytes_t s2b(input string s);
    bytes_t r;
    for (int k = 0; k < 8; k++) r[k] = (k < s.len()) ? s[k] : 8'h00;
    return r;
  endfunction

  // Byte k lives in word k/4 at bits 8*(k%4); word 0 is the upper half when flattened.
  function automatic logic [63:0] b2flat(input bytes_t b);
    logic [63:0] r = '0;
    for (int k = 0; k < 8; k++) r = r | (64'(b[k]) << ((1 - k/4) * 32 + 8 * (k % 4)));
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic model(input int idx, input int len, input bytes_t a, input bytes_t b,
                       output logic [63:0] res, output int lat);
    bytes_t r;
    int     n;
    int     w0;
    bit     word;
    bit     hit;
    r    = '{default: 8'h00};
    n    = (len == 0 || len > 8) ? 8 : len;
    word = 1'b1;
    hit  = 1'b0;
    w0   = 0;
    lat  = n + 1;
    case (idx)
      0: begin
        while (w0 < n && a[w0] != 8'h00) w0++;
        lat = (w0 < n) ? w0 + 2 : n + 1;
      end
      1: begin
        for (int k = 0; k < n; k++) begin
          if (!hit && (a[k] != b[k] || a[k] == 8'h00)) begin
            hit = 1'b1;
            w0  = int'(a[k]) - int'(b[k]);
            lat = k + 2;
          end
        end
      end
      2, 3: begin
        word = 1'b0;
        for (int k = 0; k < n; k++) begin
          r[k] = a[k];
          if (idx == 2 && a[k] >= 8'h61 && a[k] <= 8'h7A) r[k] = a[k] - 8'h20;
          if (idx == 3 && a[k] >= 8'h41 && a[k] <= 8'h5A) r[k] = a[k] + 8'h20;
        end
      end
      4: begin
        w0 = -1;
        for (int k = 0; k < n; k++) begin
          if (!hit && a[k] == b[0]) begin
            hit = 1'b1;
            w0  = k;
            lat = k + 2;
          end else if (!hit && a[k] == 8'h00) begin
            hit = 1'b1;
            lat = k + 2;
          end
        end
      end
      default: lat = 2;
    endcase
    res = word ? {w0, 32'h0} : b2flat(r);
  endtask

  // Single compare point: one negedge per call, checking done and Result against the model.
  task automatic step();
    @(negedge clk);
    if (tracking) begin
      if (cyc < 1000) cyc++;
      if (cyc < exp_lat) begin
        chk($sformatf("done_low_c%0d", cyc), 64'(done), 64'd0);
      end else begin
        chk($sformatf("done_high_c%0d", cyc), 64'(done), 64'd1);
        chk($sformatf("result_c%0d", cyc), Result, exp_res);
      end
    end
  endtask

  task automatic start_op(input int idx, input int len, input string sa, input string sb);
    bytes_t a;
    bytes_t b;
    a      = s2b(sa);
    b      = s2b(sb);
    A      = b2flat(a);
    B      = b2flat(b);
    index  = 4'(idx);
    length = 8'(len);
    model(idx, len, a, b, exp_res, exp_lat);
    go       = 1'b1;
    cyc      = 0;
    tracking = 1'b1;
  endtask

  task automatic run(input int idx, input int len, input string sa, input string sb);
    go = 1'b0;
    step();
    start_op(idx, len, sa, sb);
    repeat (exp_lat + 1) step();
  endtask

  initial begin
    reset  = 1'b1;
    go     = 1'b0;
    index  = '0;
    length = '0;
    A      = '0;
    B      = '0;
    repeat (2) @(negedge clk);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", Result, 64'd0);
    reset = 1'b0;
    step();

    run(0, 0, "Hi!", "");
    chk("strlen_lit", 64'(Result[0]), 64'd3);
    chk("strlen_lat", 64'(exp_lat), 64'd5);
    run(1, 0, "abc", "abd");
    chk("strcmp_lit", 64'(Result[0]), 64'hFFFF_FFFF);
    chk("strcmp_lat", 64'(exp_lat), 64'd4);
    run(1, 0, "abc", "abc");
    chk("strcmp_eq_lit", Result, 64'd0);
    run(2, 4, "aZ9z", "");
    chk("toupper_lit", Result, {32'h5A39_5A41, 32'h0});
    chk("toupper_lat", 64'(exp_lat), 64'd5);
    run(4, 0, "hello", "l");
    chk("find_lit", 64'(Result[0]), 64'd2);
    run(4, 0, "hello", "q");
    chk("find_miss_lit", 64'(Result[0]), 64'hFFFF_FFFF);

    run(0, 0, "abcdefgh", "");
    chk("strlen_full_lit", 64'(Result[0]), 64'd8);
    run(2, 3, "abcdefgh", "");
    run(3, 200, "ABCDEFGH", "");
    run(7, 0, "xy", "");
    run(1, 0, "z", "A");
    chk("strcmp_pos_lit", 64'(Result[0]), 64'd57);
    run(1, 2, "abX", "abY");
    run(1, 0, "abcdefgh", "abcdefgh");
    run(4, 3, "abcd", "d");

    go = 1'b0;
    step();
    start_op(2, 0, "abcdefgh", "");
    step();
    step();
    A = '0;
    B = '1;
    repeat (exp_lat) step();

    // go is still high: changing index and A must neither restart nor disturb Result.
    index = 4'd0;
    A     = b2flat(s2b("zz"));
    repeat (4) step();
    go = 1'b0;
    repeat (2) step();
    run(0, 0, "zz", "");

    go = 1'b0;
    step();
    start_op(3, 0, "ABCDEFGH", "");
    repeat (3) step();
    tracking = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_reset_done", 64'(done), 64'd0);
    chk("async_reset_result", Result, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) begin
      step();
      chk("no_start_after_reset", 64'(done), 64'd0);
    end
    run(3, 0, "ABCDEFGH", "");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
